// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared definitions for the MEM-stage data-memory access unit:
//   - size_e      : memSize encodings (code 2'b11 decodes to a word access)
//   - state_e     : access FSM states
//   - BE_*        : byte-enable patterns for the little-endian data port
//   - decode_size : maps the raw 2-bit memSize field onto size_e
//   - is_misaligned : alignment-fault predicate for a size/address pair
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic size_e decode_size(input logic [1:0] code);
        case (code)
            2'b00:   return SIZE_BYTE;
            2'b01:   return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
        case (size)
            SIZE_HALF: return lane[0];
            SIZE_WORD: return (lane != 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational lane steering for the data-memory port.
// Store side: replicates store data across the lanes and produces the byte
// enables for the addressed byte/half/word. Load side: picks the addressed
// byte/half out of the read word and sign- or zero-extends it.
// Ports:
//   i_size        access size
//   i_lane        address bits [1:0]
//   i_unsigned    zero-extend loads when 1
//   i_store_data  raw store data (rt)
//   i_load_data   raw read word from memory
//   o_be          byte enables, little-endian
//   o_wdata       lane-replicated store data
//   o_load_data   formatted, extended load result
// -----------------------------------------------------------------------------
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  size_e       i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a value unassigned and infer a latch.
    always_comb begin
        w_byte      = i_load_data[8*i_lane +: 8];
        w_half      = i_load_data[16*i_lane[1] +: 16];
        o_be        = BE_WORD;
        o_wdata     = i_store_data;
        o_load_data = i_load_data;
        case (i_size)
            SIZE_BYTE: begin
                o_be        = BE_BYTE0 << i_lane;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                o_be        = i_lane[1] ? BE_HALF_HI : BE_HALF_LO;
                o_wdata     = {2{i_store_data[15:0]}};
                o_load_data = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: begin
                o_be        = BE_WORD;
                o_wdata     = i_store_data;
                o_load_data = i_load_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM-stage data-memory access unit. Uses the EX result as effective address
// for loads/stores (or passes it through for ALU ops), runs one outstanding
// request/ack transaction on the data port, stalls upstream while it waits,
// and hands a registered, extended result to write-back.
//
// Optional feature: define MEM_TIMEOUT_EN to add an ACCESS watchdog
// (parameter TIMEOUT_CYCLES) that aborts a transaction and pulses busError.
// Without it, ACCESS waits indefinitely and busError is tied low.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   validIn            instruction present from EX/MEM latch
//   aluResult          effective address / ALU result
//   storeData          store data (rt)
//   memRead/memWrite   load / store (both set = store)
//   memSize            00 byte, 01 half, 1x word
//   loadUnsigned       zero-extend byte/half loads
//   rdIn, regWriteIn   destination register and its write enable
//   stall              hold upstream (instruction consumed when validIn & !stall)
//   dmemReq/We/Addr/Be/Wdata  data-memory request, held until dmemAck
//   dmemRdata, dmemAck read data and single-cycle completion
//   wbValid/Data/Rd/RegWrite  registered write-back result (one pulse each)
//   misaligned         one-cycle alignment-fault pulse
//   busError           one-cycle timeout-abort pulse
// -----------------------------------------------------------------------------
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        validIn,
    input  logic [31:0] aluResult,
    input  logic [31:0] storeData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  memSize,
    input  logic        loadUnsigned,
    input  logic [4:0]  rdIn,
    input  logic        regWriteIn,
    output logic        stall,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [3:0]  dmemBe,
    output logic [31:0] dmemWdata,
    input  logic [31:0] dmemRdata,
    input  logic        dmemAck,
    output logic        wbValid,
    output logic [31:0] wbData,
    output logic [4:0]  wbRd,
    output logic        wbRegWrite,
    output logic        misaligned,
    output logic        busError
);

    state_e      r_state;
    state_e      w_next_state;

    logic        r_dmem_req;
    logic        r_dmem_we;
    logic [31:0] r_dmem_addr;
    logic [3:0]  r_dmem_be;
    logic [31:0] r_dmem_wdata;
    size_e       r_size;
    logic [1:0]  r_lane;
    logic        r_unsigned;
    logic [4:0]  r_rd;
    logic        r_regwrite;

    logic        r_wb_valid;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_rd;
    logic        r_wb_regwrite;
    logic        r_misaligned;

    logic        w_mem_op;
    size_e       w_size_in;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_stall;
    logic        w_start;
    logic        w_pass;
    logic        w_finish;

    size_e       w_align_size;
    logic [1:0]  w_align_lane;
    logic        w_align_unsigned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    assign w_mem_op     = memRead | memWrite;
    assign w_size_in    = decode_size(memSize);
    assign w_misaligned = is_misaligned(w_size_in, aluResult[1:0]);

    // One aligner serves both directions: in IDLE it shapes the incoming store,
    // in ACCESS it formats the returning load from the captured size/lane.
    assign w_align_size     = (r_state == ST_ACCESS) ? r_size     : w_size_in;
    assign w_align_lane     = (r_state == ST_ACCESS) ? r_lane     : aluResult[1:0];
    assign w_align_unsigned = (r_state == ST_ACCESS) ? r_unsigned : loadUnsigned;

    mem_lane_align u_lane_align (
        .i_size       (w_align_size),
        .i_lane       (w_align_lane),
        .i_unsigned   (w_align_unsigned),
        .i_store_data (storeData),
        .i_load_data  (dmemRdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_timer;
    logic       r_bus_error;

    // r_timer is 0 on the first ACCESS cycle, so the abort fires in the
    // TIMEOUT_CYCLES-th ACCESS cycle and takes effect at the following edge.
    assign w_timeout = (r_state == ST_ACCESS) && !dmemAck && (r_timer == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer     <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_bus_error <= w_finish && w_timeout;
            if (w_start) begin
                r_timer <= '0;
            end else if (r_state == ST_ACCESS) begin
                r_timer <= r_timer + 8'd1;
            end
        end
    end

    assign busError = r_bus_error;
`else
    assign w_timeout = 1'b0;
    assign busError  = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Stall is released on the completing ACCESS cycle (ack or abort) so the
    // upstream latch advances exactly once per instruction.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_start      = 1'b0;
        w_pass       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (validIn) begin
                    if (w_mem_op && !w_misaligned) begin
                        w_stall      = 1'b1;
                        w_start      = 1'b1;
                        w_next_state = ST_ACCESS;
                    end else begin
                        w_pass = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (dmemAck || w_timeout) begin
                    w_finish     = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: captured fields are reset too, so an access aborted by reset
    // leaves nothing stale on the memory port or the write-back bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dmem_req    <= 1'b0;
            r_dmem_we     <= 1'b0;
            r_dmem_addr   <= '0;
            r_dmem_be     <= '0;
            r_dmem_wdata  <= '0;
            r_size        <= SIZE_BYTE;
            r_lane        <= '0;
            r_unsigned    <= 1'b0;
            r_rd          <= '0;
            r_regwrite    <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_data     <= '0;
            r_wb_rd       <= '0;
            r_wb_regwrite <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_misaligned  <= 1'b0;

            // Non-memory op, or a memory op rejected for alignment.
            if (w_pass) begin
                r_wb_valid    <= 1'b1;
                r_wb_data     <= aluResult;
                r_wb_rd       <= rdIn;
                r_wb_regwrite <= regWriteIn && !w_mem_op;
                r_misaligned  <= w_mem_op;
            end

            if (w_start) begin
                r_dmem_req   <= 1'b1;
                r_dmem_we    <= memWrite;
                r_dmem_addr  <= {aluResult[31:2], 2'b00};
                r_dmem_be    <= w_be;
                r_dmem_wdata <= w_wdata;
                r_size       <= w_size_in;
                r_lane       <= aluResult[1:0];
                r_unsigned   <= loadUnsigned;
                r_rd         <= rdIn;
                // memRead together with memWrite behaves as a store.
                r_regwrite   <= regWriteIn && !memWrite;
            end

            if (w_finish) begin
                r_dmem_req    <= 1'b0;
                r_wb_valid    <= 1'b1;
                r_wb_data     <= w_load_data;
                r_wb_rd       <= r_rd;
                r_wb_regwrite <= r_regwrite && !w_timeout;
            end
        end
    end

    assign stall      = w_stall;
    assign dmemReq    = r_dmem_req;
    assign dmemWe     = r_dmem_we;
    assign dmemAddr   = r_dmem_addr;
    assign dmemBe     = r_dmem_be;
    assign dmemWdata  = r_dmem_wdata;
    assign wbValid    = r_wb_valid;
    assign wbData     = r_wb_data;
    assign wbRd       = r_wb_rd;
    assign wbRegWrite = r_wb_regwrite;
    assign misaligned = r_misaligned;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage data-memory access unit, directly downstream of the EX-stage ALU. Consumes the ALU result as the effective address for LW/LH/LB/SW/SH/SB and as pass-through data for non-memory instructions. Drives a single-outstanding request/ack data-memory port with byte lanes and stalls upstream until the access completes. Presents a registered, sign/zero-extended result to write-back.

Parameters:
TIMEOUT_CYCLES, 16, cycles in ACCESS without ack before abort (only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
validIn  in  1  instruction present from EX/MEM latch
aluResult  in  32  effective address or ALU result
storeData  in  32  forwarded rt value for stores
memRead  in  1  load instruction
memWrite  in  1  store instruction
memSize  in  2  00 byte, 01 half, 10 word (11 treated as word)
loadUnsigned  in  1  zero-extend LBU/LHU
rdIn  in  5  destination register
regWriteIn  in  1  instruction writes a register
stall  out  1  hold upstream; the instruction is consumed on a cycle with validIn=1, stall=0
dmemReq  out  1  memory request, held until ack
dmemWe  out  1  1 = write
dmemAddr  out  32  word address {aluResult[31:2],2'b00}
dmemBe  out  4  byte enables, little-endian
dmemWdata  out  32  lane-replicated store data
dmemRdata  in  32  read data, valid with ack
dmemAck  in  1  single-cycle completion
wbValid  out  1  result valid to WB (one-cycle pulse per instruction)
wbData  out  32  formatted load data or aluResult
wbRd  out  5  destination register
wbRegWrite  out  1  write enable to register file
misaligned  out  1  one-cycle pulse, alignment fault
busError  out  1  one-cycle pulse, timeout abort (MEM_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; all outputs 0; captured fields cleared. Reset in ACCESS drops dmemReq at that edge; a late ack is ignored.
- States: IDLE, ACCESS.
- IDLE, validIn, no mem op: stall=0; next edge wbValid=1, wbData=aluResult, wbRd/wbRegWrite copied. Latency 1.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0. Effect: stall=0, no request. Next edge wbValid=1, wbRegWrite=0, misaligned=1.
- IDLE, validIn, aligned mem op: stall=1 combinationally. Next edge: ACCESS; dmemReq=1; dmemWe=memWrite; dmemAddr/Be/Wdata registered; size/lane/unsigned/rd captured.
- ACCESS: request outputs stable. stall = !dmemAck. Inputs ignored except that upstream holds them.
- On dmemAck: next edge IDLE, dmemReq=0, wbValid=1.
  - Load: wbData formatted from dmemRdata; wbRegWrite=captured value.
  - Store: wbRegWrite=0.
- Back-to-back: the next instruction is presented the cycle after ack and is evaluated in IDLE. Minimum 2 cycles per memory op plus wait states.
- Byte enables: byte lane k=addr[1:0] gives be=1<<k, wdata={4{storeData[7:0]}}. Half: addr[1]=0 gives 0011, 1 gives 1100; wdata={2{storeData[15:0]}}. Word: 1111.
- Load format: byte = rdata[8k+7:8k]; half = rdata[16*addr[1]+15:16*addr[1]]; extend sign unless loadUnsigned. Word passes unchanged.
- Ack in IDLE: ignored. memRead and memWrite both set: treated as store.

Optional Feature:
MEM_TIMEOUT_EN: an 8-bit counter runs in ACCESS and clears on entry. Reaching TIMEOUT_CYCLES without ack:
- next edge IDLE, dmemReq=0, stall released
- wbValid=1, wbRegWrite=0, busError=1
Without the macro: no counter; ACCESS waits indefinitely; busError tied 0.

Decomposition:
- Shared package: memSize encodings (SIZE_BYTE/HALF/WORD), state enum, byte-enable constants.
- Sub-module mem_lane_align: combinational store lane replication + byte enables and load lane select/extend; instantiated once.

Test Plan:
- SW addr 0x00000104, data 0xDEADBEEF, ack after 3 wait cycles -> dmemBe=1111, dmemAddr=0x104, stall high 4 cycles, wbValid pulse, wbRegWrite=0.
- LB addr 0x203, rdata 0x80FF7F01, signed -> wbData=0xFFFFFF80; same with loadUnsigned -> 0x00000080.
- LH addr 0x202, rdata 0x8001_1234 -> wbData=0xFFFF8001; SB addr 0x201 data 0xAB -> be=0010, wdata=0xABABABAB.
- LW addr 0x102 -> no dmemReq, stall=0, misaligned=1, wbRegWrite=0; ADDU result 0x5 following -> wbData=0x5 next cycle.
- rst_n low during ACCESS, ack arrives a cycle later -> dmemReq 0 after the edge, no wbValid.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, LW with no ack -> busError pulse after 4 ACCESS cycles, stall released.
